hardware_transmitter: RTL and testbench

Serial line transmitter for the optical link; it is the transmit end of the link that hardware_receiver decodes. It accepts parallel data words over a valid/ready handshake and drives a UART-style frame on a single line bit. Each line bit is held for SAMPLES_PER_BIT clock cycles, matching the receiver's oversampling. The frame is an idle-high line, a start bit, data bits LSB-first, and a stop bit. It sits between the packet source logic and the optical driver pin.

---
 rtl/hardware_link_pkg.sv | 19 +
 rtl/link_bit_timer.sv | 45 ++++
 rtl/hardware_transmitter.sv | 162 ++++++++++++++++
 tb/tb_hardware_transmitter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/hardware_link_pkg.sv
// rtl/hardware_link_pkg.sv - shared link state encoding and line levels
// Purpose: definitions shared by the optical-link transmitter and receiver.
// Ports: none (package).
package hardware_link_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } link_state_e;

    localparam logic LINK_IDLE_LEVEL          = 1'b1;
    localparam logic LINK_START_LEVEL         = 1'b0;
    localparam int   DEFAULT_SAMPLES_PER_BIT  = 10;
    localparam int   DEFAULT_DATA_BITS        = 8;

endpackage

// File: rtl/link_bit_timer.sv
// rtl/link_bit_timer.sv - per-bit sample counter producing a bit_done pulse
// Purpose: counts 0..SAMPLES_PER_BIT-1 while enabled; bit_done marks the last
//          sample of a line bit, after which the count wraps to 0.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-low reset
//   en       in   count enable; counter clears while low
//   bit_done out  high during the last sample cycle of a bit (comb of count)
module link_bit_timer
    import hardware_link_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = DEFAULT_SAMPLES_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_done
);

    localparam int CNT_W = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_done = en & (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (!en || bit_done) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hardware_transmitter.sv
// rtl/hardware_transmitter.sv - UART-style serial transmitter for the optical link
// Purpose: accepts words over a valid/ready handshake and sends each as
//          start bit, DATA_BITS data bits LSB-first, optional even parity bit,
//          stop bit; every line bit lasts SAMPLES_PER_BIT clocks.
// Optional feature macro: HW_TX_PARITY_EN (adds the parity bit before stop).
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-low reset
//   din        in   word to send, captured on handshake
//   din_valid  in   source offers din
//   din_ready  out  transmitter accepts din this cycle
//   dout       out  registered serial line, idle high
//   busy       out  registered, high while a frame is on the line
module hardware_transmitter
    import hardware_link_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = DEFAULT_SAMPLES_PER_BIT,
    parameter int DATA_BITS       = DEFAULT_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic                 dout,
    output logic                 busy
);

    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    link_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 dout_q, dout_d;
    logic                 busy_q, busy_d;
`ifdef HW_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic timer_en;
    logic bit_done;
    logic xfer;

    assign timer_en = (state_q != IDLE);

    link_bit_timer #(
        .SAMPLES_PER_BIT(SAMPLES_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (timer_en),
        .bit_done (bit_done)
    );

    // Ready in the last stop sample lets a waiting word start with no idle gap.
    assign din_ready = rst & ((state_q == IDLE) | ((state_q == STOP) & bit_done));
    assign xfer      = din_valid & din_ready;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
`ifdef HW_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d   = START;
                    shift_d   = din;
                    bit_idx_d = '0;
`ifdef HW_TX_PARITY_EN
                    parity_d  = ^din;
`endif
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                    if (bit_idx_q == LAST_IDX) begin
`ifdef HW_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef HW_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (xfer) begin
                        state_d   = START;
                        shift_d   = din;
                        bit_idx_d = '0;
`ifdef HW_TX_PARITY_EN
                        parity_d  = ^din;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level follows the next state so dout changes on the same edge
        // as the state register, keeping the output a clean flop.
        case (state_d)
            START:   dout_d = LINK_START_LEVEL;
            DATA:    dout_d = shift_d[0];
`ifdef HW_TX_PARITY_EN
            PARITY:  dout_d = parity_d;
`endif
            default: dout_d = LINK_IDLE_LEVEL;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            dout_q    <= LINK_IDLE_LEVEL;
            busy_q    <= 1'b0;
`ifdef HW_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            dout_q    <= dout_d;
            busy_q    <= busy_d;
`ifdef HW_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign dout = dout_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_hardware_transmitter.sv
// tb/tb_hardware_transmitter.sv - self-checking bench for hardware_transmitter
module tb_hardware_transmitter;
    import hardware_link_pkg::*;

    localparam int SPB = DEFAULT_SAMPLES_PER_BIT;
    localparam int DW  = DEFAULT_DATA_BITS;
`ifdef HW_TX_PARITY_EN
    localparam int FRAME_LEN = (DW + 3) * SPB;
`else
    localparam int FRAME_LEN = (DW + 2) * SPB;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic          dout;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_seen = 0;
    bit last_xfer = 1'b0;

    // Reference line: remaining samples still to appear on dout, front = now.
    bit line_q[$];

    hardware_transmitter #(
        .SAMPLES_PER_BIT(SPB),
        .DATA_BITS      (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .dout      (dout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic void push_level(input bit b);
        repeat (SPB) line_q.push_back(b);
    endfunction

    function automatic void push_frame(input logic [DW-1:0] w);
        push_level(1'b0);
        for (int i = 0; i < DW; i++) push_level(w[i]);
`ifdef HW_TX_PARITY_EN
        push_level(^w);
`endif
        push_level(1'b1);
    endfunction

    // One clock: check outputs mid-cycle, then advance the model across the edge.
    task automatic step();
        bit exp_ready;
        bit xfer;
        @(negedge clk);
        exp_ready = rst && (line_q.size() <= 1);
        chk("dout", dout, (line_q.size() > 0) ? line_q[0] : 1'b1);
        chk("busy", busy, (line_q.size() > 0) ? 1'b1 : 1'b0);
        chk("din_ready", din_ready, exp_ready);
        if (busy === 1'b1) busy_seen++;
        xfer = exp_ready && (din_valid === 1'b1);
        @(posedge clk);
        cyc++;
        if (!rst) begin
            line_q.delete();
        end else begin
            if (line_q.size() > 0) void'(line_q.pop_front());
            if (xfer) push_frame(din);
        end
        last_xfer = xfer;
        #1;
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        int n;
        n = 0;
        din = w;
        din_valid = 1'b1;
        do begin
            step();
            n++;
        end while (!last_xfer && n < 400);
        chk("handshake_timeout", {31'd0, last_xfer}, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        din_valid = 1'b0;
        while (line_q.size() > 0 && n < 400) begin
            step();
            n++;
        end
        chk("drain_timeout", line_q.size(), 0);
        repeat (2) step();
    endtask

    initial begin
        logic [DW-1:0] w;

        // Reset held with a pending word: nothing accepted, line idle.
        rst = 1'b0;
        din_valid = 1'b1;
        din = DW'($urandom);
        @(posedge clk);
        #1;
        repeat (3) step();
        rst = 1'b1;
        din_valid = 1'b0;
        step();

        // Single frame, with busy duration measured.
        busy_seen = 0;
        send_word(8'hA5);
        drain();
        chk("busy_len_a5", busy_seen, FRAME_LEN);

        // Back-to-back frames with valid held continuously.
        busy_seen = 0;
        send_word(8'h00);
        send_word(8'hFF);
        drain();
        chk("busy_len_b2b", busy_seen, 2 * FRAME_LEN);

        // Backpressure: second word offered at cycle 20 of a frame.
        send_word(DW'($urandom));
        din_valid = 1'b0;
        repeat (19) step();
        send_word(8'h3C);
        drain();

        // Reset in the middle of a frame.
        send_word(8'h55);
        din_valid = 1'b0;
        repeat (44) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("abort_dout", dout, 1);
        chk("abort_busy", busy, 0);
        busy_seen = 0;
        send_word(8'h81);
        drain();
        chk("busy_len_81", busy_seen, FRAME_LEN);

`ifdef HW_TX_PARITY_EN
        busy_seen = 0;
        send_word(8'h07);
        drain();
        chk("busy_len_par07", busy_seen, FRAME_LEN);
        send_word(8'h03);
        drain();
`endif

        // Random words, random gaps, random back-to-back and waiting.
        for (int k = 0; k < 30; k++) begin
            w = DW'($urandom);
            send_word(w);
            if ($urandom_range(0, 2) != 0) begin
                din_valid = 1'b0;
                repeat ($urandom_range(0, 120)) step();
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
